pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB). It decides operand forwarding for the ID->EX latch and detects load-use hazards. It sequences stalls and bubbles and squashes wrong-path instructions after a branch/jump resolves in MEM. This replaces the ad-hoc stall/flush logic in the CPU top: the top only applies the enables and selects this block produces. It also keeps saturating stall/flush event counters for performance debug.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt
REFILL_CYCLES, 1, cycles IF/ID latch stays frozen (held at nop) after a redirect; legal 1..3

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous active-high reset
id_opcode  in  7  opcode in ID stage
id_rs1  in  5  rs1 in ID stage
id_rs2  in  5  rs2 in ID stage
ex_opcode  in  7  opcode in EX stage
ex_rd  in  5  rd in EX stage
mem_opcode  in  7  opcode in MEM stage
mem_rd  in  5  rd in MEM stage
mem_branch  in  1  branch taken, resolved in MEM
mem_jump  in  1  jal in MEM
wb_rd  in  5  rd in WB stage
wb_we  in  1  WB register-file write enable
fwd_a  out  2  ID->EX operand1 source: 0 regfile, 1 EX alu result, 2 MEM (load data if load, else result), 3 WB write data
fwd_b  out  2  same encoding for operand2
pc_hold  out  1  PC must not advance this cycle
if_id_hold  out  1  IF/ID latch keeps its value
id_ex_bubble  out  1  load nop into ID/EX
flush_if_id  out  1  load nop into IF/ID
flush_id_ex  out  1  load nop into ID/EX
stall_cnt  out  CNT_W  load-use stalls taken, saturating
flush_cnt  out  CNT_W  redirects taken, saturating
busy  out  1  state != RUN

Behaviour:
- Opcode classes:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BR 1100011, JAL 1101111.
  - uses_rs1 = R|I|LOAD|STORE|BR.
  - uses_rs2 = R|STORE|BR.
  - writes_rd = R|I|LOAD|JAL.
  - Any other opcode (incl. 0 = nop) uses and writes nothing.
- Producer match requires writes_rd(stage opcode), rd != 0, and rd equal to the consumer register. x0 is never forwarded and never stalls.
- Forwarding (combinational):
  - Priority EX(non-load) = 1 > MEM = 2 > WB (wb_we & wb_rd != 0) = 3 > 0.
  - fwd_x is 0 when the operand is unused.
  - An EX LOAD match yields 0 and triggers load_use.
- load_use = ex_opcode==LOAD and a match on any used ID source.
- redirect = mem_branch | mem_jump.
- FSM states:
  - RUN:
    - redirect: flush_if_id=1, flush_id_ex=1, go to REFILL, reload refill counter to REFILL_CYCLES.
    - else load_use: pc_hold=1, if_id_hold=1, id_ex_bubble=1, go to LSTALL.
    - else stay in RUN with all control outputs 0.
  - LSTALL (exactly 1 cycle):
    - Control outputs 0; forwarding resolves the load via MEM (fwd=2); load_use cannot re-fire because EX holds a bubble.
    - redirect here: act as RUN-redirect and go to REFILL.
    - else return to RUN.
  - REFILL:
    - if_id_hold=1 and flush_if_id=1 (IF/ID held at nop); pc_hold=0.
    - Decrement counter; return to RUN when it reaches 0.
    - A redirect here flushes again and reloads the counter; load_use is ignored.
- Simultaneous events: redirect beats load_use; only flush_cnt increments.
- Counters: increment on the RUN/LSTALL->REFILL transition (flush_cnt) and the RUN->LSTALL transition (stall_cnt), including a redirect taken while already in REFILL. They hold at 2^CNT_W-1.
- Reset:
  - While rst=1, all outputs are 0, state=RUN, counters=0.
  - Reset mid-stall or mid-refill aborts immediately.
  - First decision is in the cycle after rst falls.
- Latency: control and forward outputs are combinational from inputs plus state, valid in the same cycle. State and counters update at posedge.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL)
  - fwd_sel encoding (FWD_RF, FWD_EX, FWD_MEM, FWD_WB)
  - FSM state typedef (RUN, LSTALL, REFILL)
  - uses_rs1/uses_rs2/writes_rd functions
- One sub-module operand_fwd_sel: combinational source selection for one operand, instantiated twice (rs1, rs2). FSM and counters live in the top.

Test Plan:
- ID=R(rs1=5,rs2=6), EX=I(rd=5), MEM=R(rd=6) -> fwd_a=1, fwd_b=2, no stall, state RUN.
- ID=R(rs1=3), EX=LOAD(rd=3) -> pc_hold=if_id_hold=id_ex_bubble=1 for 1 cycle. Next cycle EX=nop, MEM=LOAD(rd=3) -> fwd_a=2, stall_cnt=1, state back to RUN.
- ID=I(rs1=0), EX=I(rd=0), WB we rd=0 -> fwd_a=0, no stall.
- mem_branch=1 with load_use also true -> flush_if_id=flush_id_ex=1, pc_hold=0, REFILL for REFILL_CYCLES=1 cycle with if_id_hold=1, flush_cnt=1, stall_cnt unchanged.
- mem_jump pulse while in REFILL (REFILL_CYCLES=3) -> counter reloads, REFILL lasts 3 more cycles, flush_cnt=2.
- Force stall_cnt to 0xFFFF via 65535 load-use stalls, then one more -> stays 0xFFFF. Then rst=1 during LSTALL -> all outputs 0, counters 0, state RUN next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcode constants, forwarding-select encoding,
// hazard FSM states and opcode class helpers.
package cpu_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    REFILL = 2'd2
  } state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BR);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage decode fields in, pipeline
// enables, forwarding selects and perf counters out.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);

  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [6:0]       ex_opcode;
  logic [4:0]       ex_rd;
  logic [6:0]       mem_opcode;
  logic [4:0]       mem_rd;
  logic             mem_branch;
  logic             mem_jump;
  logic [4:0]       wb_rd;
  logic             wb_we;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             pc_hold;
  logic             if_id_hold;
  logic             id_ex_bubble;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             busy;

  modport master (
    output id_opcode, id_rs1, id_rs2, ex_opcode, ex_rd, mem_opcode, mem_rd,
           mem_branch, mem_jump, wb_rd, wb_we,
    input  fwd_a, fwd_b, pc_hold, if_id_hold, id_ex_bubble, flush_if_id,
           flush_id_ex, stall_cnt, flush_cnt, busy
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_opcode, ex_rd, mem_opcode, mem_rd,
           mem_branch, mem_jump, wb_rd, wb_we,
    output fwd_a, fwd_b, pc_hold, if_id_hold, id_ex_bubble, flush_if_id,
           flush_id_ex, stall_cnt, flush_cnt, busy
  );

endinterface

// File: rtl/operand_fwd_sel.sv
// Picks the bypass source for one ID-stage operand and flags a load in EX
// that the operand would need before its data exists.
module operand_fwd_sel
  import cpu_pkg::*;
(
  input  logic       used,
  input  logic [4:0] rs,
  input  logic [6:0] ex_opcode,
  input  logic [4:0] ex_rd,
  input  logic [6:0] mem_opcode,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       wb_we,
  output fwd_sel_e   sel,
  output logic       load_hazard
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = writes_rd(ex_opcode)  && (ex_rd  != 5'd0) && (ex_rd  == rs);
  assign mem_hit = writes_rd(mem_opcode) && (mem_rd != 5'd0) && (mem_rd == rs);
  assign wb_hit  = wb_we                 && (wb_rd  != 5'd0) && (wb_rd  == rs);

  // Youngest producer wins; a load in EX has no data yet, so it masks older stages.
  always_comb begin
    sel         = FWD_RF;
    load_hazard = 1'b0;
    if (used) begin
      if (ex_hit) begin
        if (ex_opcode == OP_LOAD) load_hazard = 1'b1;
        else                      sel         = FWD_EX;
      end else if (mem_hit) begin
        sel = FWD_MEM;
      end else if (wb_hit) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: operand forwarding, load-use stall and
// branch/jump redirect sequencing, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int REFILL_CYCLES = 1
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [1:0]       REFILL_LOAD = REFILL_CYCLES[1:0];
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_e           state_q, state_d;
  logic [1:0]       refill_q, refill_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  fwd_sel_e sel_a, sel_b;
  logic     haz_a, haz_b;
  logic     use_a, use_b;
  logic     load_use, redirect;
  logic     pc_hold, if_id_hold, id_ex_bubble, flush_if_id, flush_id_ex;

  assign use_a    = uses_rs1(bus.id_opcode);
  assign use_b    = uses_rs2(bus.id_opcode);
  assign load_use = haz_a | haz_b;
  assign redirect = bus.mem_branch | bus.mem_jump;

  operand_fwd_sel u_fwd_a (
    .used(use_a), .rs(bus.id_rs1),
    .ex_opcode(bus.ex_opcode), .ex_rd(bus.ex_rd),
    .mem_opcode(bus.mem_opcode), .mem_rd(bus.mem_rd),
    .wb_rd(bus.wb_rd), .wb_we(bus.wb_we),
    .sel(sel_a), .load_hazard(haz_a)
  );

  operand_fwd_sel u_fwd_b (
    .used(use_b), .rs(bus.id_rs2),
    .ex_opcode(bus.ex_opcode), .ex_rd(bus.ex_rd),
    .mem_opcode(bus.mem_opcode), .mem_rd(bus.mem_rd),
    .wb_rd(bus.wb_rd), .wb_we(bus.wb_we),
    .sel(sel_b), .load_hazard(haz_b)
  );

  // A redirect overrides everything in every state; load_use only acts from RUN.
  always_comb begin
    state_d      = state_q;
    refill_d     = refill_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    if (redirect) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      if_id_hold  = (state_q == REFILL);
      state_d     = REFILL;
      refill_d    = REFILL_LOAD;
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = LSTALL;
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
        LSTALL: state_d = RUN;
        REFILL: begin
          if_id_hold  = 1'b1;
          flush_if_id = 1'b1;
          refill_d    = refill_q - 2'd1;
          if (refill_q == 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      refill_q    <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      refill_q    <= refill_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset forces every output low, even before the first clock edge.
  always_comb begin
    bus.fwd_a        = FWD_RF;
    bus.fwd_b        = FWD_RF;
    bus.pc_hold      = 1'b0;
    bus.if_id_hold   = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.flush_if_id  = 1'b0;
    bus.flush_id_ex  = 1'b0;
    bus.stall_cnt    = '0;
    bus.flush_cnt    = '0;
    bus.busy         = 1'b0;
    if (!rst) begin
      bus.fwd_a        = sel_a;
      bus.fwd_b        = sel_b;
      bus.pc_hold      = pc_hold;
      bus.if_id_hold   = if_id_hold;
      bus.id_ex_bubble = id_ex_bubble;
      bus.flush_if_id  = flush_if_id;
      bus.flush_id_ex  = flush_id_ex;
      bus.stall_cnt    = stall_cnt_q;
      bus.flush_cnt    = flush_cnt_q;
      bus.busy         = (state_q != RUN);
    end
  end

endmodule
